// File: rtl/regfile_param.sv
// Purpose    : parametrised register file, 2 combinational read ports, 1 clocked write port,
//              optional hard-wired zero entry, optional write-to-read bypass, self-initialising.
// Latency    : reads 0 cycles (combinational); writes land on the next rising edge.
// Backpressure: none; producer must hold off writes until Ready=1 (writes during init are dropped).
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous active-high reset; restarts the init sequence
//   Clear      synchronous request (RUN only) to re-run the init sequence
//   RS1/RS2    read addresses
//   RD         write address; WriteData/RegWrite write data and enable
//   ReadData1/ReadData2  combinational read data (0 while not Ready)
//   Ready      contents valid, writes accepted
module regfile_param #(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 32,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Clear,
    input  logic [AW-1:0]   RS1,
    input  logic [AW-1:0]   RS2,
    input  logic [AW-1:0]   RD,
    input  logic [XLEN-1:0] WriteData,
    input  logic            RegWrite,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic            Ready
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One extra bit so that DEPTH itself is representable for the range check.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q,   cnt_d;
    logic            ready_q, ready_d;

    logic [XLEN-1:0] regs_q [DEPTH];

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    logic [XLEN-1:0] init_val;
    logic            rd_addr_ok;
    logic            run_wr;
    logic            bypass_ok;

    // ------------------------------------------------------------------
    // Init value: the counter is zero-extended into a wide vector first so
    // the same slice works whether XLEN is wider or narrower than AW
    // (narrow XLEN simply truncates the index).
    // ------------------------------------------------------------------
    always_comb begin
        logic [XLEN+AW-1:0] init_wide;
        init_wide = {{XLEN{1'b0}}, cnt_q};
        init_val  = '0;
        if (INIT_INDEX != 0) begin
            init_val = init_wide[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Write qualification. An RD that is out of range or hits the
    // hard-wired zero entry never writes and is never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        rd_addr_ok = ({1'b0, RD} < DEPTH_W);
        if ((ZERO_REG != 0) && (RD == '0)) begin
            rd_addr_ok = 1'b0;
        end
        // Clear takes priority over a coincident write.
        run_wr    = (state_q == ST_RUN) && RegWrite && !Clear && rd_addr_ok;
        // Ready is only high in RUN, so the read-side gate on Ready covers the state.
        bypass_ok = (BYPASS != 0) && RegWrite && !Clear && rd_addr_ok;
    end

    // ------------------------------------------------------------------
    // Write port mux: the init sequencer owns the array in INIT, the
    // external write port owns it in RUN.
    // ------------------------------------------------------------------
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = init_val;
        if (state_q == ST_INIT) begin
            wr_en = 1'b1;
        end else if (run_wr) begin
            wr_en   = 1'b1;
            wr_addr = RD;
            wr_data = WriteData;
        end
    end

    // The array itself has no reset; entries keep their values across a
    // reset until the sequencer overwrites them. Writes are held off while
    // reset is asserted so the array is untouched during reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST_IDX) begin
                // This edge writes the last entry, so contents are valid after it.
                state_d = ST_RUN;
                cnt_d   = '0;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (Clear) begin
                state_d = ST_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign Ready = ready_q;

    // ------------------------------------------------------------------
    // Read ports, in priority order: not ready, out of range, zero entry,
    // bypass from the write port, then the stored value.
    // ------------------------------------------------------------------
    always_comb begin
        ReadData1 = '0;
        if (!ready_q) begin
            ReadData1 = '0;
        end else if ({1'b0, RS1} >= DEPTH_W) begin
            ReadData1 = '0;
        end else if ((ZERO_REG != 0) && (RS1 == '0)) begin
            ReadData1 = '0;
        end else if (bypass_ok && (RS1 == RD)) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = regs_q[RS1];
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (!ready_q) begin
            ReadData2 = '0;
        end else if ({1'b0, RS2} >= DEPTH_W) begin
            ReadData2 = '0;
        end else if ((ZERO_REG != 0) && (RS2 == '0)) begin
            ReadData2 = '0;
        end else if (bypass_ok && (RS2 == RD)) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = regs_q[RS2];
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Purpose    : self-checking bench for regfile_param over four parameter sets sharing one stimulus.
// Latency    : expectations are queued after inputs settle and compared on the following falling edge.
// Backpressure: none; the bench drives writes freely, including during init, to check they are dropped.
module tb_regfile_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        Clear;
    logic        RegWrite;
    logic [4:0]  RS1, RS2, RD;
    logic [63:0] WriteData;

    // Parameter sets: 0 default, 1 no bypass, 2 no zero register, 3 DEPTH=24/XLEN=8/zero init.
    localparam int DEP [4] = '{32, 32, 32, 24};
    localparam int XL  [4] = '{64, 64, 64, 8};
    localparam int ZR  [4] = '{1, 1, 0, 1};
    localparam int BP  [4] = '{1, 0, 1, 1};
    localparam int II  [4] = '{1, 1, 1, 0};

    logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
    logic [7:0]  d_rd1, d_rd2;
    logic        a_rdy, b_rdy, c_rdy, d_rdy;

    regfile_param #(.XLEN(64), .DEPTH(32), .ZERO_REG(1), .BYPASS(1), .INIT_INDEX(1)) u_a (
        .clk(clk), .reset(reset), .Clear(Clear), .RS1(RS1), .RS2(RS2), .RD(RD),
        .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(a_rd1), .ReadData2(a_rd2), .Ready(a_rdy));

    regfile_param #(.XLEN(64), .DEPTH(32), .ZERO_REG(1), .BYPASS(0), .INIT_INDEX(1)) u_b (
        .clk(clk), .reset(reset), .Clear(Clear), .RS1(RS1), .RS2(RS2), .RD(RD),
        .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(b_rd1), .ReadData2(b_rd2), .Ready(b_rdy));

    regfile_param #(.XLEN(64), .DEPTH(32), .ZERO_REG(0), .BYPASS(1), .INIT_INDEX(1)) u_c (
        .clk(clk), .reset(reset), .Clear(Clear), .RS1(RS1), .RS2(RS2), .RD(RD),
        .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(c_rd1), .ReadData2(c_rd2), .Ready(c_rdy));

    regfile_param #(.XLEN(8), .DEPTH(24), .ZERO_REG(1), .BYPASS(1), .INIT_INDEX(0)) u_d (
        .clk(clk), .reset(reset), .Clear(Clear), .RS1(RS1), .RS2(RS2), .RD(RD),
        .WriteData(WriteData[7:0]), .RegWrite(RegWrite),
        .ReadData1(d_rd1), .ReadData2(d_rd2), .Ready(d_rdy));

    // ------------------------------------------------------------------
    // Reference model: contents as a plain array, init modelled as
    // "DEPTH edges of not-ready, after which every entry holds its init
    // value".
    // ------------------------------------------------------------------
    logic [63:0] mem [4][32];
    int          init_left [4];

    typedef struct {
        int          k;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        erdy;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] msk(input int k, input logic [63:0] v);
        if (XL[k] >= 64) return v;
        return v & ((64'd1 << XL[k]) - 64'd1);
    endfunction

    function automatic logic [63:0] exp_read(input int k, input logic [4:0] rs);
        if (init_left[k] != 0) return 64'd0;
        if (int'(rs) >= DEP[k]) return 64'd0;
        if (ZR[k] != 0 && rs == 5'd0) return 64'd0;
        if (BP[k] != 0 && RegWrite && !Clear && RD == rs) return msk(k, WriteData);
        return mem[k][rs];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                init_left[k] = DEP[k];
            end else if (init_left[k] > 0) begin
                init_left[k]--;
                if (init_left[k] == 0) begin
                    for (int i = 0; i < DEP[k]; i++) begin
                        mem[k][i] = (II[k] != 0) ? msk(k, 64'(i)) : 64'd0;
                    end
                end
            end else if (Clear) begin
                init_left[k] = DEP[k];
            end else if (RegWrite && int'(RD) < DEP[k] && !(ZR[k] != 0 && RD == 5'd0)) begin
                mem[k][RD] = msk(k, WriteData);
            end
        end
    endtask

    task automatic push_exp();
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.k    = k;
            e.e1   = exp_read(k, RS1);
            e.e2   = exp_read(k, RS2);
            e.erdy = (init_left[k] == 0);
            sb.push_back(e);
        end
    endtask

    // One cycle: let the edge happen, advance the model on the inputs that
    // were sampled, then drive new inputs and queue what the DUTs must show.
    task automatic step(input logic rst, input logic clr, input logic we,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [63:0] wd);
        @(posedge clk);
        model_edge();
        #1;
        reset     = rst;
        Clear     = clr;
        RegWrite  = we;
        RD        = rd;
        RS1       = rs1;
        RS2       = rs2;
        WriteData = wd;
        if (rst) begin
            for (int k = 0; k < 4; k++) init_left[k] = DEP[k];
        end
        push_exp();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: consumes the scoreboard on every falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] r1, r2;
            logic        ry;
            e = sb.pop_front();
            case (e.k)
                0:       begin r1 = a_rd1; r2 = a_rd2; ry = a_rdy; end
                1:       begin r1 = b_rd1; r2 = b_rd2; ry = b_rdy; end
                2:       begin r1 = c_rd1; r2 = c_rd2; ry = c_rdy; end
                default: begin r1 = {56'd0, d_rd1}; r2 = {56'd0, d_rd2}; ry = d_rdy; end
            endcase
            chk($sformatf("dut%0d ReadData1", e.k), r1, e.e1);
            chk($sformatf("dut%0d ReadData2", e.k), r2, e.e2);
            chk($sformatf("dut%0d Ready", e.k), {63'd0, ry}, {63'd0, e.erdy});
        end
    end

    initial begin
        reset     = 1'b1;
        Clear     = 1'b0;
        RegWrite  = 1'b0;
        RD        = 5'd0;
        RS1       = 5'd0;
        RS2       = 5'd0;
        WriteData = 64'd0;
        for (int k = 0; k < 4; k++) init_left[k] = DEP[k];
        #1;
        push_exp();

        // Hold reset a few cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0);

        // Release, writes attempted during init, then reset again at cnt=10.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 5'd3, 5'(i), 5'(31 - i), 64'hAA);
        step(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 64'hAA);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 64'd0);

        // Second release: a full init with a write to RD=3 held throughout.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 5'd3, 5'(i), 5'(31 - i), 64'hAA);

        // Sweep every address on both ports.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'(i), 5'(31 - i), 64'd0);

        // Write then read, same cycle (bypass) and next cycle.
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 64'hDEADBEEF);
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 64'd0);

        // Zero register write.
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 64'hFF);
        step(1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 64'd0);

        // Clear colliding with a write.
        step(1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 64'h1234);
        for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 64'd0);

        // Writes to the top addresses, then read them back.
        for (int i = 24; i < 32; i++)
            step(1'b0, 1'b0, 1'b1, 5'(i), 5'(i), 5'(i - 8), {$urandom, $urandom});
        for (int i = 24; i < 32; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'(i), 5'(i - 8), 64'd0);

        // Randomised traffic.
        for (int n = 0; n < 500; n++) begin
            logic [4:0] rd, r1, r2;
            logic       we, clr, rst;
            rd  = 5'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            we  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 249) == 0);
            step(rst, clr, we, rd, r1, r2, {$urandom, $urandom});
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file for the single-cycle datapath: two combinational read ports, one clocked write port, optional hard-wired zero register, and optional write-to-read bypass. After reset, or on a clear request, a built-in sequencer loads every entry with its index value (or zero), one entry per cycle. `Ready` flags when the contents are valid. It sits between instruction decode and the ALU/writeback mux, in the same position as the current fixed 32×64 file.

## Interface
- `XLEN`, 64: data width in bits.
- `DEPTH`, 32: number of registers, ≥2; `AW = $clog2(DEPTH)` is the address width.
- `ZERO_REG`, 1: 1 means entry 0 always reads 0 and ignores writes.
- `BYPASS`, 1: 1 means a same-cycle write to an address being read is forwarded to that read port.
- `INIT_INDEX`, 1: 1 means the init sequence loads entry i with value i (zero-extended); 0 means it loads 0.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Clear`  in  1  synchronous request to re-run the init sequence.
- `RS1`  in  AW  read address, port 1.
- `RS2`  in  AW  read address, port 2.
- `RD`  in  AW  write address.
- `WriteData`  in  XLEN  write data.
- `RegWrite`  in  1  write enable.
- `ReadData1`  out  XLEN  read data, port 1 (combinational).
- `ReadData2`  out  XLEN  read data, port 2 (combinational).
- `Ready`  out  1  high when the contents are valid and writes are accepted.

## Operation
- FSM has two states: INIT and RUN.
- While `reset` is high:
  - state = INIT, init counter `cnt` = 0, `Ready` = 0.
  - The register array is not reset asynchronously.
- INIT state:
  - Each rising edge writes `Registers[cnt]` with `cnt` (if `INIT_INDEX`=1) or 0, then increments `cnt`.
  - The edge that writes entry DEPTH-1 moves the FSM to RUN and sets `Ready` = 1.
  - `RegWrite` is ignored (the write is dropped) and `Clear` is ignored.
- RUN state:
  - A rising edge with `RegWrite`=1 writes `WriteData` into `Registers[RD]`.
  - The write is suppressed when `ZERO_REG`=1 and `RD`==0.
- `Clear`=1 in RUN:
  - On the next edge: state moves to INIT, `cnt` = 0, `Ready` = 0.
  - A simultaneous `RegWrite` is dropped; `Clear` wins.
- Read ports, evaluated in this priority order:
  1. `Ready`=0 → output 0.
  2. Address ≥ DEPTH (non-power-of-two DEPTH) → output 0.
  3. `ZERO_REG`=1 and address 0 → output 0.
  4. `BYPASS`=1, `RegWrite`=1, `RD`==`RSx`, and the write is not suppressed (and `Clear`=0) → output `WriteData`.
  5. Otherwise → output `Registers[RSx]`.
- Addresses ≥ DEPTH on `RD`: write ignored.
- Init values are truncated to XLEN bits if DEPTH-1 does not fit in XLEN (no wrap error).
- `reset` asserted mid-INIT or mid-RUN restarts INIT from `cnt`=0. Entries already written keep their values until overwritten by the sequence.

## Timing
- Reset values: `Ready`=0, `ReadData1`=`ReadData2`=0.
- `Ready` rises exactly DEPTH rising edges after `reset` deasserts.
- Reset deassertion is assumed to be synchronised to `clk` upstream.
- Read latency is 0 cycles: combinational from `RS1`, `RS2`, `RD`, `WriteData`, `RegWrite`, and `Ready`.
- Write latency is 1 edge. Without bypass, the new value is visible on the cycle after the write edge.
- With `BYPASS`=1, the new value is visible on the read port in the same cycle as `RegWrite`.
- `Clear` costs DEPTH cycles of `Ready`=0, starting the cycle after `Clear` is sampled.
- Only one write per cycle. No back-pressure; the producer must hold off writes until `Ready`=1.

## Test plan
- Reset then init, default params: release `reset`, read every address after `Ready`.
  - Required: `Ready`=0 for exactly 32 edges, then 1.
  - Required: `ReadData1` = i for each `RS1`=i; reads are 0 while `Ready`=0.
- Write then read: RUN, `RD`=5, `WriteData`=0xDEADBEEF, `RegWrite`=1.
  - Required: with `BYPASS`=1, `ReadData1`=0xDEADBEEF in the same cycle with `RS1`=5.
  - Required: with `BYPASS`=0, old value 5 in that cycle and 0xDEADBEEF the next cycle.
- Zero register: write `RD`=0, `WriteData`=0xFF.
  - Required: `ReadData2` with `RS2`=0 stays 0, including the bypass cycle.
  - Required: with `ZERO_REG`=0, reads 0xFF the next cycle.
- Clear collision: `Clear`=1 together with `RegWrite`=1, `RD`=7, data 0x1234.
  - Required: `Ready` falls next cycle and stays low 32 cycles.
  - Required: after init, `RS1`=7 reads 7, not 0x1234.
- Writes during init: drive `RegWrite`=1, `RD`=3, data 0xAA throughout INIT.
  - Required: after `Ready`, `RS1`=3 reads 3.
- Reset mid-init and odd depth: DEPTH=24, XLEN=8, INIT_INDEX=0; assert `reset` at `cnt`=10.
  - Required: `Ready` rises 24 edges after the second release.
  - Required: addresses 24–31 read 0 and writes to them are ignored.
